// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: clears x0..x31 after reset, then
// round-robin arbitrates two writeback requesters onto one write port.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   a_valid/a_rd/a_data      requester A (ALU writeback) request
//   a_ready                  A accepted this cycle (combinational)
//   b_valid/b_rd/b_data      requester B (load writeback) request
//   b_ready                  B accepted this cycle (combinational)
//   regwrite/writereg/writedata  registered register-file write port
//   init_done                high once the clear sequence has finished
module regfile_wb_arbiter #(
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_rd,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_rd,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic        regwrite,
    output logic [4:0]  writereg,
    output logic [31:0] writedata,
    output logic        init_done
);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam logic [4:0] LAST = 5'(NREGS - 1);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        ptr_q, ptr_d;       // 0: A has priority, 1: B has priority
    logic        regwrite_q, regwrite_d;
    logic [4:0]  writereg_q, writereg_d;
    logic [31:0] writedata_q, writedata_d;
    logic        init_done_q, init_done_d;
    logic        a_gnt, b_gnt;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        regwrite_d  = 1'b0;
        writereg_d  = writereg_q;
        writedata_d = writedata_q;
        init_done_d = init_done_q;
        a_gnt       = 1'b0;
        b_gnt       = 1'b0;

        case (state_q)
            S_INIT: begin
                regwrite_d  = 1'b1;
                writereg_d  = cnt_q;
                writedata_d = '0;
                cnt_d       = cnt_q + 5'd1;
                if (cnt_q == LAST) begin
                    state_d     = S_RUN;
                    init_done_d = 1'b1;
                end
            end
            S_RUN: begin
                // Readies are combinational, so gate them with rst to keep
                // a request from handshaking while the block is being reset.
                if (!rst) begin
                    a_gnt = a_valid && (!b_valid || !ptr_q);
                    b_gnt = b_valid && (!a_valid || ptr_q);
                end
                if (a_gnt) begin
                    ptr_d      = 1'b1;
                    regwrite_d = (a_rd != 5'd0);
                    if (a_rd != 5'd0) begin
                        writereg_d  = a_rd;
                        writedata_d = a_data;
                    end
                end else if (b_gnt) begin
                    ptr_d      = 1'b0;
                    regwrite_d = (b_rd != 5'd0);
                    if (b_rd != 5'd0) begin
                        writereg_d  = b_rd;
                        writedata_d = b_data;
                    end
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            ptr_q       <= 1'b0;
            regwrite_q  <= 1'b0;
            writereg_q  <= '0;
            writedata_q <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            regwrite_q  <= regwrite_d;
            writereg_q  <= writereg_d;
            writedata_q <= writedata_d;
            init_done_q <= init_done_d;
        end
    end

    assign a_ready   = a_gnt;
    assign b_ready   = b_gnt;
    assign regwrite  = regwrite_q;
    assign writereg  = writereg_q;
    assign writedata = writedata_q;
    assign init_done = init_done_q;

endmodule
